// File: rtl/vram_term_if.sv
// Character-terminal bus: CPU display port in, VRAM write port and
// cursor/scroll status out.
interface vram_term_if;
    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        clr_req;
    logic [10:0] vram_waddr;
    logic        vram_wen;
    logic [5:0]  vram_din;
    logic [4:0]  top_row;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    // CPU / stimulus side
    modport master (
        output char_in, char_valid, clr_req,
        input  char_ready, vram_waddr, vram_wen, vram_din,
               top_row, cursor_col, cursor_row, busy
    );

    // Terminal controller side
    modport slave (
        input  char_in, char_valid, clr_req,
        output char_ready, vram_waddr, vram_wen, vram_din,
               top_row, cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/vram_term_ctrl.sv
// Text-mode terminal controller: turns a stream of ASCII characters into
// VRAM writes, tracks the cursor, scrolls by moving top_row and blanks the
// recycled line, and clears the whole screen on reset or request.
module vram_term_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 24
) (
    input logic        clk,
    input logic        rst,
    vram_term_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WRITE    = 3'd1;
    localparam logic [2:0] NEWLINE  = 3'd2;
    localparam logic [2:0] CLR_LINE = 3'd3;
    localparam logic [2:0] CLR_ALL  = 3'd4;

    localparam logic [10:0] CELLS        = 11'(COLS * ROWS);
    localparam logic [10:0] CNT_COL_LAST = 11'(COLS - 1);
    localparam logic [5:0]  COL_LAST     = 6'(COLS - 1);
    localparam logic [4:0]  ROW_LAST     = 5'(ROWS - 1);
    localparam logic [5:0]  BLANK        = 6'h20;

    logic [2:0]  state, state_nxt;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row, top_row;
    logic [10:0] cnt;
    logic [10:0] waddr;
    logic        wen;
    logic [5:0]  din;
    logic        busy;

    logic        accept, is_print, is_cr;
    logic [5:0]  phys_row_sum;
    logic [4:0]  phys_row;
    logic [10:0] cur_addr;
    logic [5:0]  glyph;

    // Character decode and cursor address (physical row wraps modulo ROWS)
    always_comb begin
        is_print     = (bus.char_in >= 7'h20) && (bus.char_in <= 7'h7E);
        is_cr        = (bus.char_in == 7'h0D);
        glyph        = bus.char_in[5:0] - ((bus.char_in >= 7'h60) ? 6'h20 : 6'h00);
        phys_row_sum = {1'b0, top_row} + {1'b0, cursor_row};
        phys_row     = (phys_row_sum >= 6'(ROWS)) ? 5'(phys_row_sum - 6'(ROWS))
                                                  : phys_row_sum[4:0];
        cur_addr     = 11'(phys_row) * 11'(COLS) + 11'(cursor_col);
    end

    // A pending clear request blocks acceptance in the same cycle so the
    // clear always wins over a simultaneous character.
    assign bus.char_ready = ~busy & ~bus.clr_req;
    assign accept         = bus.char_valid & bus.char_ready;

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.clr_req)
                    state_nxt = CLR_ALL;
                else if (accept)
                    state_nxt = is_print ? WRITE : (is_cr ? NEWLINE : IDLE);
            end
            WRITE:    state_nxt = (cursor_col == COL_LAST) ? NEWLINE : IDLE;
            NEWLINE:  state_nxt = (cursor_row == ROW_LAST) ? CLR_LINE : IDLE;
            CLR_LINE: if (cnt == CNT_COL_LAST) state_nxt = IDLE;
            CLR_ALL:  if (cnt == CELLS) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State, cursor, scroll and registered VRAM write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLR_ALL;
            busy       <= 1'b1;
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
            cnt        <= '0;
            waddr      <= '0;
            wen        <= 1'b0;
            din        <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            wen   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        cnt <= '0;
                    end else if (accept && is_print) begin
                        wen   <= 1'b1;
                        waddr <= cur_addr;
                        din   <= glyph;
                    end
                end
                WRITE: begin
                    // Last column leaves the cursor for NEWLINE to wrap
                    if (cursor_col != COL_LAST)
                        cursor_col <= cursor_col + 6'd1;
                end
                NEWLINE: begin
                    cursor_col <= '0;
                    if (cursor_row != ROW_LAST) begin
                        cursor_row <= cursor_row + 5'd1;
                    end else begin
                        // Scroll: old top line becomes the new bottom line;
                        // prime its first blank write here so the clear runs
                        // one cell per cycle for exactly COLS cycles.
                        top_row <= (top_row == ROW_LAST) ? 5'd0 : top_row + 5'd1;
                        wen     <= 1'b1;
                        waddr   <= 11'(top_row) * 11'(COLS);
                        din     <= BLANK;
                        cnt     <= '0;
                    end
                end
                CLR_LINE: begin
                    if (cnt != CNT_COL_LAST) begin
                        wen   <= 1'b1;
                        waddr <= waddr + 11'd1;
                        cnt   <= cnt + 11'd1;
                    end
                end
                CLR_ALL: begin
                    if (cnt != CELLS) begin
                        wen   <= 1'b1;
                        waddr <= cnt;
                        din   <= BLANK;
                        cnt   <= cnt + 11'd1;
                    end else begin
                        cursor_col <= '0;
                        cursor_row <= '0;
                        top_row    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vram_waddr = waddr;
    assign bus.vram_wen   = wen;
    assign bus.vram_din   = din;
    assign bus.top_row    = top_row;
    assign bus.cursor_col = cursor_col;
    assign bus.cursor_row = cursor_row;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_vram_term_ctrl.sv
// Self-checking bench for vram_term_ctrl: expected VRAM writes go into a
// scoreboard queue when stimulus is driven and are popped by a monitor.
module tb_vram_term_ctrl;
    logic clk;
    logic rst;

    vram_term_if bus ();

    vram_term_ctrl #(.COLS(40), .ROWS(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [10:0] a;
        logic [5:0]  d;
    } wr_t;

    typedef struct {
        logic [6:0] ch;
        bit         wr;
        logic [5:0] d;
        int         col;
        int         row;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[11];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_col  = 0;
    int   m_row  = 0;
    int   m_top  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor: every observed write must match the queue head
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.vram_wen) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected",
                         bus.vram_waddr, bus.vram_din);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", int'(bus.vram_waddr), int'(e.a));
                chk("write_data", int'(bus.vram_din), int'(e.d));
                chk("busy_during_write", int'(bus.busy), 1);
            end
        end
    end

    function automatic logic [10:0] addr_of();
        return 11'(((m_top + m_row) % 24) * 40 + m_col);
    endfunction

    function automatic logic [5:0] glyph_of(input logic [6:0] c);
        logic [6:0] t;
        t = (c >= 7'h60) ? c - 7'h20 : c;
        return t[5:0];
    endfunction

    task automatic push_clear_all();
        for (int i = 0; i < 960; i++) exp_q.push_back('{11'(i), 6'h20});
        m_col = 0;
        m_row = 0;
        m_top = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_within_budget"}, int'(n < budget), 1);
        chk({name, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic check_cursor(input string name);
        chk({name, "_cursor_col"}, int'(bus.cursor_col), m_col);
        chk({name, "_cursor_row"}, int'(bus.cursor_row), m_row);
        chk({name, "_top_row"}, int'(bus.top_row), m_top);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_wen"}, int'(bus.vram_wen), 0);
        chk({name, "_char_ready"}, int'(bus.char_ready), 0);
        chk({name, "_waddr"}, int'(bus.vram_waddr), 0);
        chk({name, "_din"}, int'(bus.vram_din), 0);
        chk({name, "_top_row"}, int'(bus.top_row), 0);
        chk({name, "_cursor_col"}, int'(bus.cursor_col), 0);
        chk({name, "_cursor_row"}, int'(bus.cursor_row), 0);
        chk({name, "_busy"}, int'(bus.busy), 1);
    endtask

    // One-cycle character transfer; a printable must strobe the very next cycle
    task automatic send_char(input logic [6:0] c, input bit wr);
        @(negedge clk);
        chk("char_ready_before_send", int'(bus.char_ready), 1);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        chk("write_strobe_next_cycle", int'(bus.vram_wen), int'(wr));
    endtask

    // Model-driven character: pushes expected writes (including scroll clears)
    task automatic put(input logic [6:0] c);
        bit wr;
        bit nl;
        wr = 0;
        nl = 0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            wr = 1;
            exp_q.push_back('{addr_of(), glyph_of(c)});
            if (m_col == 39) nl = 1;
            else m_col++;
        end else if (c == 7'h0D) begin
            nl = 1;
        end
        if (nl) begin
            m_col = 0;
            if (m_row < 23) begin
                m_row++;
            end else begin
                for (int i = 0; i < 40; i++) exp_q.push_back('{11'(m_top * 40 + i), 6'h20});
                m_top = (m_top + 1) % 24;
            end
        end
        send_char(c, wr);
        wait_idle(200, "put");
        check_cursor("put");
    endtask

    initial begin
        int  n;
        bit  hit;

        vecs[0]  = '{7'h41, 1'b1, 6'h01, 1, 0};
        vecs[1]  = '{7'h61, 1'b1, 6'h01, 2, 0};
        vecs[2]  = '{7'h20, 1'b1, 6'h20, 3, 0};
        vecs[3]  = '{7'h5F, 1'b1, 6'h1F, 4, 0};
        vecs[4]  = '{7'h7E, 1'b1, 6'h1E, 5, 0};
        vecs[5]  = '{7'h60, 1'b1, 6'h00, 6, 0};
        vecs[6]  = '{7'h07, 1'b0, 6'h00, 6, 0};
        vecs[7]  = '{7'h7F, 1'b0, 6'h00, 6, 0};
        vecs[8]  = '{7'h1F, 1'b0, 6'h00, 6, 0};
        vecs[9]  = '{7'h0D, 1'b0, 6'h00, 0, 1};
        vecs[10] = '{7'h5A, 1'b1, 6'h1A, 1, 1};

        rst            = 1'b1;
        bus.char_in    = '0;
        bus.char_valid = 1'b0;
        bus.clr_req    = 1'b0;

        // Reset values while held
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Power-up blanking
        rst = 1'b0;
        push_clear_all();
        wait_idle(1200, "init_clear");
        chk("init_char_ready", int'(bus.char_ready), 1);
        check_cursor("init");

        // Table-driven character mapping from cursor 0,0
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) exp_q.push_back('{11'(m_row * 40 + m_col), vecs[i].d});
            send_char(vecs[i].ch, vecs[i].wr);
            wait_idle(200, "vec");
            chk($sformatf("vec%0d_cursor_col", i), int'(bus.cursor_col), vecs[i].col);
            chk($sformatf("vec%0d_cursor_row", i), int'(bus.cursor_row), vecs[i].row);
            m_col = vecs[i].col;
            m_row = vecs[i].row;
        end

        // Full row at row 5 with auto-wrap
        for (int i = 0; i < 4; i++) put(7'h0D);
        chk("row5_setup", int'(bus.cursor_row), 5);
        for (int i = 0; i < 40; i++) put(7'(7'h40 + i));
        chk("row_wrap_col", int'(bus.cursor_col), 0);
        chk("row_wrap_row", int'(bus.cursor_row), 6);

        // Scroll at the bottom row, then write through the wrapped row
        for (int i = 0; i < 17; i++) put(7'h0D);
        chk("bottom_setup", int'(bus.cursor_row), 23);
        put(7'h0D);
        chk("scroll_top_row", int'(bus.top_row), 1);
        for (int i = 0; i < 40; i++) put(7'(7'h61 + (i % 26)));
        chk("wrap_scroll_top_row", int'(bus.top_row), 2);

        // Clear request wins over a simultaneous character
        @(negedge clk);
        bus.clr_req    = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_in    = 7'h41;
        #1;
        chk("clr_blocks_ready", int'(bus.char_ready), 0);
        push_clear_all();
        @(posedge clk);
        #1;
        bus.clr_req    = 1'b0;
        bus.char_valid = 1'b0;
        chk("clr_busy", int'(bus.busy), 1);
        wait_idle(1200, "clr_all");
        check_cursor("clr_all");

        // Reset in the middle of a line clear
        for (int i = 0; i < 23; i++) put(7'h0D);
        for (int i = 0; i < 17; i++) exp_q.push_back('{11'(i), 6'h20});
        send_char(7'h0D, 1'b0);
        n   = 0;
        hit = 0;
        while (!hit && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.vram_wen && bus.vram_waddr == 11'd17) hit = 1;
        end
        chk("clr_line_reached_col17", int'(hit), 1);
        rst = 1'b1;
        #1;
        chk("wen_drops_on_reset", int'(bus.vram_wen), 0);
        chk("clr_line_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        push_clear_all();
        wait_idle(1200, "restart_clear");
        chk("restart_char_ready", int'(bus.char_ready), 1);
        check_cursor("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
